// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction prefetch slice.
package fetch_pkg;
    localparam int unsigned INSTR_BYTES      = 4;
    localparam int unsigned DEFAULT_XLEN     = 32;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] instr;
        logic [DEFAULT_XLEN-1:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/instr_prefetch_if.sv
// Instruction memory request/response bus between the prefetcher (master) and memory (slave).
interface instr_prefetch_if
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
);
    logic [XLEN-1:0] memreq_addr;
    logic            memreq_valid;
    logic            memreq_ready;
    logic [XLEN-1:0] memresp_data;
    logic            memresp_valid;

    modport master (
        output memreq_addr, memreq_valid,
        input  memreq_ready, memresp_data, memresp_valid
    );

    modport slave (
        input  memreq_addr, memreq_valid,
        output memreq_ready, memresp_data, memresp_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; storage is not reset, only pointers and count.
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !clear && (count != FULL);
    assign do_pop  = pop && !clear && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher: credit-limited requests, in-order responses into a PC-tagged FIFO.
module instr_prefetch
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN            = DEFAULT_XLEN,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    input  logic                    stall,
    instr_prefetch_if.master        mem,
    output logic [XLEN-1:0]         instr_decode,
    output logic [XLEN-1:0]         pc_decode,
    output logic [XLEN-1:0]         next_pc_decode,
    output logic                    valid
);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam logic [CW1-1:0]  DEPTH_LIM = CW1'(DEPTH);
    localparam logic [CW-1:0]   OS_LIM    = CW'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] STEP      = XLEN'(INSTR_BYTES);

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW1-1:0]  used;
    logic            run;
    logic            req_fire;
    logic            resp_ok;
    logic            push;
    logic            pop;
    entry_t          head;
    entry_t          wr_entry;
    logic            unused_ok;

    assign unused_ok = &{1'b0, redirect_pc[1:0]};
    assign target    = {redirect_pc[XLEN-1:2], 2'b00};
    assign used      = {1'b0, fifo_count} + {1'b0, outstanding};

    // run holds requests off until the first edge after reset release
    assign mem.memreq_valid = run && !redirect_valid && (used < DEPTH_LIM) && (outstanding < OS_LIM);
    assign mem.memreq_addr  = fetch_pc;

    assign req_fire = mem.memreq_valid && mem.memreq_ready;
    assign resp_ok  = mem.memresp_valid && (outstanding != '0);
    assign push     = resp_ok && (drop_cnt == '0) && !redirect_valid;
    assign pop      = valid && !stall && !redirect_valid;
    assign wr_entry = '{instr: mem.memresp_data, pc: resp_pc};

    assign valid          = (fifo_count != '0);
    assign instr_decode   = valid ? head.instr : '0;
    assign pc_decode      = valid ? head.pc : '0;
    assign next_pc_decode = valid ? head.pc + STEP : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run <= 1'b1;
            if (redirect_valid) begin
                // everything still in flight belongs to the old path, including a response landing now
                fetch_pc    <= target;
                resp_pc     <= target;
                outstanding <= outstanding - CW'(resp_ok);
                drop_cnt    <= outstanding - CW'(resp_ok);
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + STEP;
                if (resp_ok) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
                    else                resp_pc  <= resp_pc + STEP;
                end
                outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect_valid),
        .din   (wr_entry),
        .dout  (head),
        .count (fifo_count)
    );
endmodule

// File: tb/tb_instr_prefetch.sv
// Scoreboard bench for instr_prefetch: memory models return ~addr, monitors check every decode pop.
module tb_instr_prefetch;
    import fetch_pkg::*;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] instr_decode, pc_decode, next_pc_decode;
    logic        valid;
    logic [31:0] d1_instr, d1_pc, d1_next;
    logic        d1_valid;

    instr_prefetch_if #(.XLEN(32)) bus0 ();
    instr_prefetch_if #(.XLEN(32)) bus1 ();

    instr_prefetch #(
        .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .mem(bus0), .instr_decode(instr_decode), .pc_decode(pc_decode),
        .next_pc_decode(next_pc_decode), .valid(valid)
    );

    instr_prefetch #(
        .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .stall(1'b0), .mem(bus1), .instr_decode(d1_instr), .pc_decode(d1_pc),
        .next_pc_decode(d1_next), .valid(d1_valid)
    );

    int tests = 0;
    int fails = 0;
    fetch_entry_t exp0[$];
    fetch_entry_t exp1[$];
    req_t         mq[$];
    int unsigned  cyc = 0;
    int unsigned  lat = 1;
    logic         mem_ready = 1'b1;
    logic [31:0]  last_acc = '0;
    logic         hs0 = 1'b0;
    logic         m1_pend = 1'b0;
    logic [31:0]  m1_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic resp_now();
        return (mq.size() > 0) && (mq[0].due <= cyc);
    endfunction

    // Called at a falling edge with this cycle's stimulus already applied; returns at the next falling edge.
    task automatic step();
        if (resp_now()) begin
            bus0.memresp_valid = 1'b1;
            bus0.memresp_data  = ~mq[0].addr;
        end else begin
            bus0.memresp_valid = 1'b0;
            bus0.memresp_data  = '0;
        end
        bus0.memreq_ready  = mem_ready;
        bus1.memresp_valid = m1_pend;
        bus1.memresp_data  = ~m1_addr;
        #1;
        if (bus0.memresp_valid) void'(mq.pop_front());
        hs0 = bus0.memreq_valid && bus0.memreq_ready;
        if (hs0) begin
            mq.push_back('{addr: bus0.memreq_addr, due: cyc + lat});
            last_acc = bus0.memreq_addr;
        end
        m1_pend = bus1.memreq_valid && bus1.memreq_ready;
        m1_addr = bus1.memreq_addr;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic load_exp0(input logic [31:0] base, input int n);
        logic [31:0] a;
        exp0.delete();
        for (int k = 0; k < n; k++) begin
            a = base + 32'(k * 4);
            exp0.push_back('{instr: ~a, pc: a});
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (reset && valid && !stall && !redirect_valid) begin
            if (exp0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m0_unexpected: actual pc=%h required no pop", pc_decode);
            end else begin
                fetch_entry_t e;
                e = exp0.pop_front();
                check("m0_pc", pc_decode, e.pc);
                check("m0_instr", instr_decode, e.instr);
                check("m0_next_pc", next_pc_decode, e.pc + 32'd4);
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (reset && d1_valid) begin
            if (exp1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL m1_unexpected: actual pc=%h required no pop", d1_pc);
            end else begin
                fetch_entry_t e;
                e = exp1.pop_front();
                check("m1_pc", d1_pc, e.pc);
                check("m1_instr", d1_instr, e.instr);
                check("m1_next_pc", d1_next, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first;
        int budget;
        logic [31:0] a;

        stall = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus0.memreq_ready = 1'b1;
        bus0.memresp_valid = 1'b0;
        bus0.memresp_data = '0;
        bus1.memreq_ready = 1'b1;
        bus1.memresp_valid = 1'b0;
        bus1.memresp_data = '0;
        load_exp0(32'h0, 64);
        for (int k = 0; k < 400; k++) begin
            a = 32'hFFFF_FFF8 + 32'(k * 4);
            exp1.push_back('{instr: ~a, pc: a});
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_memreq_valid", {31'b0, bus0.memreq_valid}, 32'd0);
        check("rst_memreq_addr", bus0.memreq_addr, 32'h0);
        check("rst_instr", instr_decode, 32'h0);
        check("rst_pc", pc_decode, 32'h0);
        check("rst_next_pc", next_pc_decode, 32'h0);
        check("rst_wrap_addr", bus1.memreq_addr, 32'hFFFF_FFF8);
        check("rst_wrap_memreq_valid", {31'b0, bus1.memreq_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Stalled fill: first valid timing, credit exhaustion
        first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            if (valid) first = int'(cyc);
            else step();
        end
        check("first_valid_cycle", 32'(first), 32'd3);
        while (cyc < 10) step();
        check("full_memreq_valid", {31'b0, bus0.memreq_valid}, 32'd0);
        check("full_memreq_addr", bus0.memreq_addr, 32'h10);
        check("full_head_pc", pc_decode, 32'h0);
        check("full_head_instr", instr_decode, 32'hFFFF_FFFF);

        // Release stall and stream
        stall = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 12; i++) begin
            check("stream_valid", {31'b0, valid}, 32'd1);
            step();
        end

        // Memory back-pressure
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_memreq_addr", bus0.memreq_addr, last_acc + 32'd4);
            check("hold_memreq_valid", {31'b0, bus0.memreq_valid}, 32'd1);
            step();
        end
        mem_ready = 1'b1;
        repeat (6) step();

        // Redirect with two requests in flight and no response this cycle
        lat = 3;
        budget = 20;
        while (!(mq.size() == 2 && !resp_now()) && budget > 0) begin
            step();
            budget--;
        end
        check("redir1_found", 32'(budget > 0), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        load_exp0(32'h100, 32);
        step();
        redirect_valid = 1'b0;
        check("redir1_no_req", {31'b0, hs0}, 32'd0);
        check("redir1_valid", {31'b0, valid}, 32'd0);
        check("redir1_addr", bus0.memreq_addr, 32'h100);
        budget = 60;
        while (exp0.size() > 29 && budget > 0) begin
            step();
            budget--;
        end
        check("redir1_progress", 32'(exp0.size() <= 29), 32'd1);

        // Redirect coinciding with a response and a pop
        lat = 1;
        repeat (8) step();
        budget = 20;
        while (!(resp_now() && valid && mq.size() == 1) && budget > 0) begin
            step();
            budget--;
        end
        check("redir2_found", 32'(budget > 0), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        load_exp0(32'h200, 32);
        step();
        redirect_valid = 1'b0;
        check("redir2_no_req", {31'b0, hs0}, 32'd0);
        check("redir2_valid", {31'b0, valid}, 32'd0);
        check("redir2_empty_pc", pc_decode, 32'h0);
        check("redir2_empty_next", next_pc_decode, 32'h0);
        check("redir2_empty_instr", instr_decode, 32'h0);
        budget = 40;
        while (exp0.size() > 26 && budget > 0) begin
            step();
            budget--;
        end
        check("redir2_progress", 32'(exp0.size() <= 26), 32'd1);

        check("wrap_progress", 32'(exp1.size() <= 397), 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Parametrised successor to the single-register fetch stage. It sits between the memory request port and decode. It keeps up to MAX_OUTSTANDING sequential fetch requests in flight to a variable-latency instruction memory. Returned instructions are buffered, tagged with their PC, in a DEPTH-entry FIFO. On an execute-stage redirect it discards queued and in-flight instructions without stalling the memory interface.

## Interface
- XLEN, 32, address/data width
- DEPTH, 4, prefetch FIFO entries (power of two, ≥2)
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered requests (1..DEPTH)
- RESET_PC, 32'h00000000, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous active-low reset
- redirect_valid  in  1  taken branch/jump/flush from execute
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored (forced 0)
- stall  in  1  decode not accepting; head entry held
- memreq_addr  out  XLEN  request address (current fetch PC)
- memreq_valid  out  1  request offered
- memreq_ready  in  1  memory accepts request this cycle
- memresp_data  in  XLEN  returned instruction word, in request order
- memresp_valid  in  1  response present this cycle
- instr_decode  out  XLEN  head instruction (0 when empty)
- pc_decode  out  XLEN  PC of head instruction (0 when empty)
- next_pc_decode  out  XLEN  pc_decode + 4 (0 when empty)
- valid  out  1  head entry valid for decode

## Operation
- State: fetch_pc, resp_pc (PC of oldest in-flight request), outstanding count, drop_cnt, FIFO (XLEN instr + XLEN pc per entry). Counters are $clog2(DEPTH+1) bits wide.
- Credits = DEPTH − fifo_count − outstanding. memreq_valid = !redirect_valid && credits>0 && outstanding<MAX_OUTSTANDING. The FIFO therefore can never overflow.
- Request handshake: memreq_valid && memreq_ready. Then fetch_pc += 4 and outstanding += 1. memreq_addr is stable while valid && !ready.
- Response with drop_cnt==0: push {memresp_data, resp_pc}, then resp_pc += 4 and outstanding −= 1.
- Response with drop_cnt>0: discard it; drop_cnt −= 1 and outstanding −= 1.
- memresp_valid with outstanding==0 is a protocol violation. It is ignored, with no state change.
- Pop: valid && !stall removes the head.
- Redirect (priority over all else in that cycle):
  - fetch_pc ← resp_pc ← {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO cleared.
  - No request is issued.
  - drop_cnt ← outstanding minus 1 if a response arrives this cycle; that response is itself dropped.
  - The pop is suppressed.
- Simultaneous push and pop in one cycle both take effect; the count is unchanged.
- PC arithmetic is modulo 2^XLEN; wrap-around from all-ones−3 to 0 is legal.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - fetch_pc = resp_pc = RESET_PC.
  - outstanding = drop_cnt = 0, FIFO empty.
  - valid = 0, memreq_valid = 0, instr_decode = pc_decode = next_pc_decode = 0.
  - memreq_addr = RESET_PC.
- First request: memreq_valid rises in the first cycle after reset deasserts.
- Latency: a response in cycle t gives valid=1 with that instruction in cycle t+1 (registered push, no bypass).
- A redirect in cycle t gives valid=0 in t+1. The first request to the new target is offered in t+1.
- Reset mid-operation loses all in-flight requests. The memory side must be reset together with this block.
- Throughput: 1 instr/cycle sustained when memory latency ≤ MAX_OUTSTANDING cycles and decode is not stalled.

## Structure
- Shared package fetch_pkg: INSTR_BYTES=4, XLEN default, RESET_PC default, FIFO entry struct {instr, pc}.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/clear; count output; same clk and reset). It holds the entries.
- Credit, outstanding and drop logic live in instr_prefetch.

## Test plan
- Reset, memreq_ready=1, 1-cycle memory, stall=0 → requests at 0,4,8,…. valid=1 from cycle 3 after reset release. pc_decode increments by 4 every cycle; next_pc_decode = pc+4.
- stall=1 held, DEPTH=4, MAX_OUTSTANDING=2 → at most 4 entries buffered. memreq_valid drops once credits reach 0. On release, four consecutive pops show PCs 0,4,8,C and nothing is lost.
- 3-cycle memory latency, 2 requests in flight, redirect_pc=0x100 → both late responses dropped. The next valid head is pc 0x100 with the data returned for address 0x100.
- Redirect in the same cycle as a response and a pop → response dropped, FIFO empty next cycle, drop_cnt = outstanding−1.
- memreq_ready=0 for 5 cycles → memreq_addr held constant, fetch_pc unchanged, no FIFO change.
- RESET_PC=32'hFFFFFFF8 → fetch sequence FFFFFFF8, FFFFFFFC, 00000000. next_pc_decode wraps to 0.
